// File: rtl/shifter_param.sv
// Parametrised shift/LFSR register with a step prescaler and runtime mode select.
// Optional per-nibble seven-segment outputs are built when SHIFTER_SEG_EN is defined.
module shifter_param #(
  parameter int               WIDTH     = 8,
  parameter int               DIV       = 0,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'b0001_1101),
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_num,
  input  logic [2:0]       i_mode,
  input  logic             i_en,
  input  logic             i_ser,
  output logic [WIDTH-1:0] o_num,
  output logic             o_step
`ifdef SHIFTER_SEG_EN
  ,
  output logic [7*(WIDTH/4)-1:0] o_seg
`endif
);

  localparam int               CNT_W    = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV);

  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] num_p0;
  logic             vld_p0;
  logic             tick;

  function automatic logic [WIDTH-1:0] shift_next(input logic [2:0]       mode,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic             ser);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    case (mode)
      3'b001:  shift_next = {x[WIDTH-2:0], ser};
      3'b010:  shift_next = {ser, x[WIDTH-1:1]};
      3'b011:  shift_next = xs >>> 1;
      3'b100:  shift_next = {x[WIDTH-2:0], x[WIDTH-1]};
      3'b101:  shift_next = {x[0], x[WIDTH-1:1]};
      // An all-zero LFSR would stick forever; restart it from the reset seed.
      3'b110:  shift_next = (x == '0) ? RESET_VAL : {^(x & TAPS), x[WIDTH-1:1]};
      default: shift_next = x;
    endcase
  endfunction

  assign tick = i_en && (cnt_p0 == CNT_LAST);

  // Stage p0: prescaler, register and step pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num_p0 <= RESET_VAL;
      cnt_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (i_load) begin
      num_p0 <= i_num;
      cnt_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= tick;
      if (tick) begin
        num_p0 <= shift_next(i_mode, num_p0, i_ser);
        cnt_p0 <= '0;
      end else if (i_en) begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end
    end
  end

  assign o_num  = num_p0;
  assign o_step = vld_p0;

`ifdef SHIFTER_SEG_EN
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  for (genvar k = 0; k < WIDTH / 4; k++) begin : g_seg
    assign o_seg[7*k +: 7] = hex7(num_p0[4*k +: 4]);
  end
`endif

endmodule

// File: doc/shifter_param.md
# shifter_param

Parametrised shift/LFSR unit that generalises the fixed 8-bit shifter: configurable width, runtime-selectable shift mode, synchronous parallel load, and a built-in step prescaler. It holds one WIDTH-bit register, advances it once per prescaler tick, and optionally drives one seven-segment hex digit per nibble. It sits between board inputs (switches/buttons) and the display/LED outputs in the digital-circuit lab tops.

## Interface
- WIDTH, 8: register width; multiple of 4, ≥ 4.
- DIV, 0: prescaler terminal count; a step occurs every DIV+1 enabled cycles.
- TAPS, 8'b0001_1101: LFSR feedback mask, WIDTH bits.
- RESET_VAL, 1: register value after reset and LFSR lock-up escape value; must be non-zero.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_load  input  1  parallel load strobe.
- i_num  input  WIDTH  parallel load data.
- i_mode  input  3  shift mode, sampled on each step.
- i_en  input  1  prescaler count enable.
- i_ser  input  1  serial fill bit for logical shifts.
- o_num  output  WIDTH  register contents.
- o_step  output  1  one-cycle pulse, high in the cycle o_num shows a stepped value.
- o_seg  output  7*(WIDTH/4)  hex digits, active-low, present only with SHIFTER_SEG_EN.

## Operation
- Priority per edge: i_rst > i_load > step > hold.
- Reset: o_num=RESET_VAL, prescaler count cnt=0, o_step=0.
- Load: o_num<=i_num, cnt<=0, o_step<=0; no step that cycle even if a tick was due.
- Prescaler: if i_en and cnt==DIV → tick, cnt<=0; else if i_en → cnt<=cnt+1; else cnt holds. Width of cnt = clog2(DIV+1), min 1 bit.
- On tick, o_num <= f(i_mode, o_num), o_step<=1; otherwise o_step<=0.
- Modes (x = o_num, W = WIDTH):
  - 000 hold: x unchanged (o_step still pulses).
  - 001 LSL: {x[W-2:0], i_ser}.
  - 010 LSR: {i_ser, x[W-1:1]}.
  - 011 ASR: {x[W-1], x[W-1:1]}.
  - 100 ROL: {x[W-2:0], x[W-1]}.
  - 101 ROR: {x[0], x[W-1:1]}.
  - 110 LFSR: {^(x & TAPS), x[W-1:1]}; if x==0, next = RESET_VAL (lock-up escape).
  - 111 reserved: behaves as hold.
- i_mode changes do not reset cnt; the mode at the tick edge applies.

## Timing
- o_num, o_step registered; update visible one cycle after the qualifying edge inputs.
- DIV=0, i_en held high: one step every cycle, o_step continuously high.
- DIV=N: first step N+1 enabled cycles after reset/load; i_en low cycles are not counted.
- Reset mid-count discards progress; first step again DIV+1 enabled cycles later.
- o_seg combinational from o_num; no added latency.

## Configuration
- SHIFTER_SEG_EN defined: o_seg present; digit k at o_seg[7k+6:7k] decodes o_num[4k+3:4k], bit order {g,f,e,d,c,b,a}, active-low (0 → 7'b1000000, F → 7'b0001110).
- Undefined: o_seg port and decoders absent; rest of block identical.

## Test plan
- Reset, WIDTH=8, DIV=0, mode 110, i_en=1 → o_num 0x01, 0x80, 0x40, 0x20, 0x10, 0x88 on successive cycles; o_step high from the first step.
- Load 0x00, mode 110, one step → o_num=0x01 (lock-up escape), not 0x00.
- Load 0x96 then one step each: ASR → 0xCB; load 0x81: ROL → 0x03, ROR → 0xC0, LSL with i_ser=0 → 0x02, LSR with i_ser=1 → 0xC0.
- DIV=3, mode 100, i_en=1 with i_en dropped for 2 cycles after cycle 2 → first step after 6 clocks; o_step exactly one cycle wide.
- i_load and tick on the same edge → o_num=i_num, o_step=0, next step DIV+1 enabled cycles later; i_rst asserted with i_load → o_num=RESET_VAL.
- SHIFTER_SEG_EN, o_num=0x3A → o_seg[6:0]=7'b0001000 (A), o_seg[13:7]=7'b0110000 (3).
